// File: rtl/collapse_sched_pkg.sv
// Shared types for the collapse-register key scheduler.
// Slot lifecycle, controller states and key width.
package collapse_sched_pkg;

   localparam int KEY_W = 8;

   typedef enum logic [1:0] {
      SLOT_EMPTY,
      SLOT_ARMED,
      SLOT_SPENT,
      SLOT_DEAD
   } slot_state_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROV,
      S_READ,
      S_RESP
   } sched_state_t;

endpackage

// File: rtl/collapse_key_scheduler_rr_arbiter.sv
// Round-robin arbiter: the pointer marks the highest-priority requester.
// The pointer moves past the grantee only when the caller commits a grant.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic          found;

   // Scan from the pointer upwards, then wrap to the low indices.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && req[j] && (j >= int'(ptr_q))) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
      for (int j = 0; j < N; j++) begin
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
   end

   // Next pointer is the grantee plus one, wrapping at N.
   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         if (gnt_idx == IW'(N - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx + IW'(1);
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/collapse_key_scheduler.sv
// Provisions read-once key slots and serves key requests round-robin.
// Each slot is read at most once; spent and dead slots stay retired.
module collapse_key_scheduler
   import collapse_sched_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   parameter  int NUM_REQ   = 2,
   localparam int SW = $clog2(NUM_SLOTS),
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW = $clog2(NUM_SLOTS + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       prov_valid,
   input  logic [KEY_W-1:0]           prov_data,
   output logic                       prov_ready,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [KEY_W-1:0]           resp_data,
   output logic [IW-1:0]              resp_id,
   output logic [SW-1:0]              resp_slot,
   output logic                       resp_err,
   output logic [NUM_SLOTS-1:0]       slot_init,
   output logic [KEY_W-1:0]           slot_entropy,
   output logic [NUM_SLOTS-1:0]       slot_read,
   input  logic [KEY_W*NUM_SLOTS-1:0] slot_key,
   input  logic [NUM_SLOTS-1:0]       slot_oe,
   output logic [CW-1:0]              armed_count,
   output logic                       busy
);

   sched_state_t state_q, state_d;
   slot_state_t  slot_q [NUM_SLOTS];
   slot_state_t  slot_d [NUM_SLOTS];

   logic [SW-1:0]        tgt_q, tgt_d;
   logic [IW-1:0]        id_q, id_d;
   logic [NUM_SLOTS-1:0] slot_init_q, slot_init_d;
   logic [NUM_SLOTS-1:0] slot_read_q, slot_read_d;
   logic [KEY_W-1:0]     slot_entropy_q, slot_entropy_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [KEY_W-1:0]     resp_data_q, resp_data_d;
   logic [IW-1:0]        resp_id_q, resp_id_d;
   logic [SW-1:0]        resp_slot_q, resp_slot_d;
   logic                 resp_err_q, resp_err_d;
   logic [CW-1:0]        armed_count_q, armed_count_d;

   logic [KEY_W-1:0]     key_arr [NUM_SLOTS];
   logic                 armed_any, empty_any;
   logic [SW-1:0]        armed_idx, empty_idx;
   logic                 rd_go, prov_go;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IW-1:0]        arb_idx;

   // Split the packed key bus into one fragment per slot.
   always_comb begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
         key_arr[k] = slot_key[k*KEY_W +: KEY_W];
      end
   end

   // Lowest-index ARMED and EMPTY slots; scanning downwards keeps the lowest.
   always_comb begin
      armed_any = 1'b0;
      armed_idx = '0;
      empty_any = 1'b0;
      empty_idx = '0;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (slot_q[k] == SLOT_ARMED) begin
            armed_any = 1'b1;
            armed_idx = SW'(k);
         end
         if (slot_q[k] == SLOT_EMPTY) begin
            empty_any = 1'b1;
            empty_idx = SW'(k);
         end
      end
   end

   // Reads win over provisioning; no handshake is offered during reset.
   always_comb begin
      rd_go   = !reset && (state_q == S_IDLE) &&
                (|req_valid) && armed_any;
      prov_go = !reset && (state_q == S_IDLE) && !rd_go &&
                prov_valid && empty_any;
   end

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (rd_go),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // Controller next state, strobe launch and response capture.
   always_comb begin
      state_d        = state_q;
      tgt_d          = tgt_q;
      id_d           = id_q;
      slot_d         = slot_q;
      slot_init_d    = '0;
      slot_read_d    = '0;
      slot_entropy_d = '0;
      resp_valid_d   = resp_valid_q;
      resp_data_d    = resp_data_q;
      resp_id_d      = resp_id_q;
      resp_slot_d    = resp_slot_q;
      resp_err_d     = resp_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (rd_go) begin
               state_d                = S_READ;
               tgt_d                  = armed_idx;
               id_d                   = arb_idx;
               slot_read_d[armed_idx] = 1'b1;
            end else if (prov_go) begin
               state_d                = S_PROV;
               tgt_d                  = empty_idx;
               slot_init_d[empty_idx] = 1'b1;
               slot_entropy_d         = prov_data;
            end
         end
         S_PROV: begin
            slot_d[tgt_q] = SLOT_ARMED;
            state_d       = S_IDLE;
         end
         S_READ: begin
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            resp_slot_d  = tgt_q;
            if (slot_oe[tgt_q]) begin
               resp_data_d   = key_arr[tgt_q];
               resp_err_d    = 1'b0;
               slot_d[tgt_q] = SLOT_SPENT;
            end else begin
               resp_data_d   = '0;
               resp_err_d    = 1'b1;
               slot_d[tgt_q] = SLOT_DEAD;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               resp_data_d  = '0;
               resp_id_d    = '0;
               resp_slot_d  = '0;
               resp_err_d   = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Count ARMED slots of the next table so the output tracks one edge later.
   always_comb begin
      armed_count_d = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (slot_d[k] == SLOT_ARMED) begin
            armed_count_d = armed_count_d + CW'(1);
         end
      end
   end

   // State, slot table and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         tgt_q          <= '0;
         id_q           <= '0;
         slot_init_q    <= '0;
         slot_read_q    <= '0;
         slot_entropy_q <= '0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_id_q      <= '0;
         resp_slot_q    <= '0;
         resp_err_q     <= 1'b0;
         armed_count_q  <= '0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_q[k] <= SLOT_EMPTY;
         end
      end else begin
         state_q        <= state_d;
         tgt_q          <= tgt_d;
         id_q           <= id_d;
         slot_init_q    <= slot_init_d;
         slot_read_q    <= slot_read_d;
         slot_entropy_q <= slot_entropy_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_id_q      <= resp_id_d;
         resp_slot_q    <= resp_slot_d;
         resp_err_q     <= resp_err_d;
         armed_count_q  <= armed_count_d;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_q[k] <= slot_d[k];
         end
      end
   end

   assign req_ready    = rd_go ? arb_gnt : '0;
   assign prov_ready   = prov_go;
   assign slot_init    = slot_init_q;
   assign slot_read    = slot_read_q;
   assign slot_entropy = slot_entropy_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_id      = resp_id_q;
   assign resp_slot    = resp_slot_q;
   assign resp_err     = resp_err_q;
   assign armed_count  = armed_count_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_collapse_key_scheduler.sv
// Bench for collapse_key_scheduler: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-level model.
module tb_collapse_key_scheduler;

   localparam int NS = 4;
   localparam int NR = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          prov_valid;
   logic [7:0]    prov_data;
   logic          prov_ready;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   logic          resp_valid;
   logic          resp_ready;
   logic [7:0]    resp_data;
   logic [0:0]    resp_id;
   logic [1:0]    resp_slot;
   logic          resp_err;
   logic [NS-1:0] slot_init;
   logic [7:0]    slot_entropy;
   logic [NS-1:0] slot_read;
   logic [8*NS-1:0] slot_key;
   logic [NS-1:0] slot_oe;
   logic [2:0]    armed_count;
   logic          busy;

   always #5 clk = ~clk;

   collapse_key_scheduler #(
      .NUM_SLOTS (NS),
      .NUM_REQ   (NR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .prov_valid   (prov_valid),
      .prov_data    (prov_data),
      .prov_ready   (prov_ready),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_id      (resp_id),
      .resp_slot    (resp_slot),
      .resp_err     (resp_err),
      .slot_init    (slot_init),
      .slot_entropy (slot_entropy),
      .slot_read    (slot_read),
      .slot_key     (slot_key),
      .slot_oe      (slot_oe),
      .armed_count  (armed_count),
      .busy         (busy)
   );

   // Read-once slot emulation; a fused slot never enables its output.
   logic [NS-1:0] live;
   logic [NS-1:0] fuse;
   logic [7:0]    mem [NS];

   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) begin
         if (reset) begin
            live[k] <= 1'b0;
         end else begin
            if (slot_init[k]) begin
               live[k] <= 1'b1;
               mem[k]  <= slot_entropy;
            end
            if (slot_read[k]) live[k] <= 1'b0;
         end
      end
   end

   always_comb begin
      slot_key = '0;
      slot_oe  = '0;
      for (int k = 0; k < NS; k++) begin
         slot_oe[k] = live[k] & ~fuse[k];
         if (slot_oe[k]) slot_key[8*k +: 8] = mem[k];
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Model: 0 idle, 1 provisioning, 2 reading, 3 responding.
   // Slot codes: 0 empty, 1 armed, 2 spent, 3 dead.
   int         m_mode = 0;
   int         m_st [NS];
   int         m_key [NS];
   int         m_rr = 0;
   int         m_tgt = 0;
   int         m_id = 0;
   int         m_byte = 0;
   int         e_data = 0;
   int         e_err = 0;

   logic [NR-1:0] pend  = '0;
   logic          ppend = 1'b0;
   logic [7:0]    pbyte = '0;

   task automatic step(input bit rst, input bit rr);
      int na, fa, fe, g, c;
      bit can_rd, can_pv;
      reset      = rst;
      prov_valid = ppend;
      prov_data  = pbyte;
      req_valid  = pend;
      resp_ready = rr;
      #1;
      na = 0; fa = -1; fe = -1; g = -1;
      for (int k = 0; k < NS; k++) begin
         if (m_st[k] == 1) begin
            na++;
            if (fa < 0) fa = k;
         end
         if (m_st[k] == 0 && fe < 0) fe = k;
      end
      can_rd = !rst && m_mode == 0 && pend != 0 && na > 0;
      if (can_rd) begin
         for (int i = 0; i < NR; i++) begin
            c = (m_rr + i) % NR;
            if (pend[c] && g < 0) g = c;
         end
      end
      can_pv = !rst && m_mode == 0 && !can_rd && ppend && fe >= 0;
      chk("req_ready", 32'(req_ready), can_rd ? (1 << g) : 0);
      chk("prov_ready", 32'(prov_ready), 32'(can_pv));
      chk("slot_init", 32'(slot_init), m_mode == 1 ? (1 << m_tgt) : 0);
      chk("slot_entropy", 32'(slot_entropy), m_mode == 1 ? m_byte : 0);
      chk("slot_read", 32'(slot_read), m_mode == 2 ? (1 << m_tgt) : 0);
      chk("resp_valid", 32'(resp_valid), 32'(m_mode == 3));
      if (m_mode == 3) begin
         chk("resp_data", 32'(resp_data), e_data);
         chk("resp_err", 32'(resp_err), e_err);
         chk("resp_id", 32'(resp_id), m_id);
         chk("resp_slot", 32'(resp_slot), m_tgt);
      end
      chk("armed_count", 32'(armed_count), na);
      chk("busy", 32'(busy), 32'(m_mode != 0));
      if (rst) begin
         m_mode = 0;
         m_rr   = 0;
         for (int k = 0; k < NS; k++) m_st[k] = 0;
      end else begin
         case (m_mode)
            0: begin
               if (can_rd) begin
                  m_mode = 2; m_tgt = fa; m_id = g; m_rr = (g + 1) % NR;
               end else if (can_pv) begin
                  m_mode = 1; m_tgt = fe; m_byte = int'(pbyte);
               end
            end
            1: begin
               m_st[m_tgt]  = 1;
               m_key[m_tgt] = m_byte;
               m_mode       = 0;
            end
            2: begin
               e_err        = fuse[m_tgt] ? 1 : 0;
               e_data       = fuse[m_tgt] ? 0 : m_key[m_tgt];
               m_st[m_tgt]  = fuse[m_tgt] ? 3 : 2;
               m_mode       = 3;
            end
            default: begin
               if (rr) m_mode = 0;
            end
         endcase
      end
      if (can_rd) pend[g] = 1'b0;
      if (can_pv) ppend = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic provision(input logic [7:0] b);
      ppend = 1'b1;
      pbyte = b;
      repeat (3) step(1'b0, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < NS; k++) begin
         m_st[k]  = 0;
         m_key[k] = 0;
      end
      fuse       = '0;
      reset      = 1'b1;
      prov_valid = 1'b0;
      prov_data  = '0;
      req_valid  = '0;
      resp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // reset state, then provision two bytes into slots 0 and 1
      step(1'b0, 1'b0);
      provision(8'h3C);
      provision(8'hA7);
      chk("armed_after_two", 32'(armed_count), 2);

      // single read from req0, response held one cycle before accept
      pend = 2'b01;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);

      // both requesters held from a fresh pointer, then a starved request
      step(1'b1, 1'b0);
      provision(8'h11);
      provision(8'h22);
      pend = 2'b11;
      repeat (8) step(1'b0, 1'b1);
      pend = 2'b01;
      repeat (4) step(1'b0, 1'b1);
      chk("starved_pending", 32'(pend), 1);

      // fused slot reports an error and is never revisited
      pend = '0;
      step(1'b1, 1'b0);
      fuse[0] = 1'b1;
      provision(8'h55);
      pend = 2'b01;
      repeat (4) step(1'b0, 1'b1);
      provision(8'h66);

      // provisioning and a request arrive together: the read wins
      ppend = 1'b1;
      pbyte = 8'h99;
      pend  = 2'b10;
      repeat (8) step(1'b0, 1'b1);

      // reset lands while a read strobe is out
      pend = 2'b01;
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      fuse = '0;

      // random traffic with occasional resets and fused slots
      for (int n = 0; n < 3000; n++) begin
         bit rst;
         if (!ppend && $urandom_range(3) == 0) begin
            ppend = 1'b1;
            pbyte = 8'($urandom);
         end
         for (int r = 0; r < NR; r++) begin
            if (!pend[r] && $urandom_range(2) == 0) pend[r] = 1'b1;
         end
         rst = ($urandom_range(49) == 0);
         if (rst) begin
            for (int k = 0; k < NS; k++) fuse[k] = ($urandom_range(3) == 0);
         end
         step(rst, 1'($urandom_range(1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/collapse_key_scheduler.md
# collapse_key_scheduler

Sequencing controller for a bank of `collapse_register_keyexchange` read-once key slots. It provisions empty slots from an entropy stream and arbitrates key-fragment requests from several consumers round-robin. It issues exactly one read strobe per granted request and tracks every slot's lifecycle, so no slot is ever read twice or read while killed. It sits between the entropy source/key consumers and the slot instances, and shares `clk`/`reset` with them.

## Interface
- `NUM_SLOTS`, 4: number of attached collapse-register slots (2..16)
- `NUM_REQ`, 2: number of key-consumer requesters (1..8)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `prov_valid`  in  1  entropy byte offered for provisioning
- `prov_data`  in  8  entropy byte
- `prov_ready`  out  1  one-cycle accept pulse
- `req_valid`  in  NUM_REQ  per-requester key request, held until accepted
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse
- `resp_valid`  out  1  response available; held until `resp_ready`
- `resp_ready`  in  1  consumer accepts response
- `resp_data`  out  8  captured key fragment (0 on error)
- `resp_id`  out  $clog2(NUM_REQ)  index of the granted requester
- `resp_slot`  out  $clog2(NUM_SLOTS)  slot that was read
- `resp_err`  out  1  slot refused the read (`slot_oe` low at read edge)
- `slot_init`  out  NUM_SLOTS  one-hot init strobe to a slot
- `slot_entropy`  out  8  shared entropy bus to all slots
- `slot_read`  out  NUM_SLOTS  one-hot read strobe to a slot
- `slot_key`  in  8*NUM_SLOTS  per-slot `key_fragment`, slot k at [8k+7:8k]
- `slot_oe`  in  NUM_SLOTS  per-slot `output_enable`
- `armed_count`  out  $clog2(NUM_SLOTS+1)  slots currently ARMED
- `busy`  out  1  FSM not in IDLE

## Operation
- Slot table: one 2-bit state per slot. EMPTY→ARMED on provisioning; ARMED→SPENT on a read with `slot_oe`=1; ARMED→DEAD on a read with `slot_oe`=0. SPENT and DEAD are terminal until `reset`; they are never re-initialised.
- FSM states: IDLE, PROV, READ, RESP.
- IDLE, read grant: taken when any `req_valid` is high and `armed_count`>0.
  - Round-robin picks the requester; `req_ready` pulses for it this cycle.
  - Target slot = lowest-index ARMED slot.
  - Next state READ.
- IDLE, provisioning: taken only when no read grant fires, `prov_valid`=1 and an EMPTY slot exists. Reads have priority.
  - `prov_ready` pulses; `prov_data` is registered; the lowest-index EMPTY slot is targeted.
  - Next state PROV.
- PROV: drive `slot_init[k]`=1 and `slot_entropy` = registered byte for one cycle. The slot becomes ARMED at this edge. Return to IDLE.
- READ: drive `slot_read[k]`=1 for exactly one cycle. The same cycle, sample `slot_key[k]`/`slot_oe[k]` at the edge.
  - `slot_oe`=1: capture data; slot becomes SPENT.
  - `slot_oe`=0: data=0, `resp_err`=1; slot becomes DEAD.
  - Next state RESP.
- RESP: `resp_valid`=1 with stable `resp_*` until `resp_ready`. Return to IDLE on the accept edge.
- Round-robin pointer moves to grantee+1 (mod NUM_REQ) on each grant.
- No ARMED slot: requests wait with `req_ready`=0; they are never dropped.
- No EMPTY slot: `prov_ready` stays 0.
- `slot_entropy` is 0 outside PROV.
- At most one of `slot_init`/`slot_read` bits is high in any cycle.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE; all slots EMPTY; RR pointer 0; `armed_count`=0.
- Grant to `slot_read`: +1 cycle. Grant to `resp_valid`: +2 cycles.
- Minimum request-to-request spacing: 3 cycles (grant, READ, RESP accepted at once).
- Provision accept to slot ARMED: `slot_init` asserted the cycle after `prov_ready`; ARMED and visible in `armed_count` the following cycle.
- `armed_count` is registered; it updates the cycle after the causing edge.
- `reset` mid-operation: any in-flight strobe is dropped the next cycle and the response is discarded. Slots reset together with the scheduler (same reset net), so EMPTY is consistent.

## Structure
- `collapse_sched_pkg`:
  - `slot_state_t` enum (SLOT_EMPTY, SLOT_ARMED, SLOT_SPENT, SLOT_DEAD).
  - `sched_state_t` enum (S_IDLE, S_PROV, S_READ, S_RESP).
  - Key width constant 8.
- Sub-module `rr_arbiter` (parameter N): request vector + advance strobe in, one-hot grant + index out, pointer register inside.
- Lowest-index ARMED/EMPTY find-first is local combinational logic.

## Test plan
- Provision 0x3C then 0xA7: `slot_init` = 0001 then 0010, each one cycle; `armed_count` reaches 2.
- req0 with slots 0/1 ARMED, slot model returns 0x3C with oe=1: `slot_read`=0001 one cycle; `resp_data`=0x3C, `resp_id`=0, `resp_slot`=0, `resp_err`=0; slot0 SPENT.
- req0 and req1 both held high with 2 ARMED: grants go req0 then req1; second response is `resp_slot`=1; a third request stalls with `armed_count`=0.
- Slot model drives `slot_oe`=0 (fused): `resp_err`=1, `resp_data`=0x00; slot DEAD and never re-read or re-initialised.
- `prov_valid` and `req_valid` rise in the same cycle with 1 ARMED: read granted first; `prov_ready` is delayed until IDLE is re-entered after the response is accepted.
- `reset` asserted during READ: next cycle all strobes are 0, `resp_valid`=0 and `armed_count`=0.
